move_seq: RTL and testbench

Command sequencer that drives the `move` motor block's `req`/`op`/`operand`/`done` handshake from the initiator side. A host (UART/SPI command decoder) pushes move commands into a small FIFO. The sequencer issues them one at a time, holds `req` until the motor block reports `done`, then releases and advances. It sits between the host command path and `move`, and replaces ad-hoc top-level `req` toggling.

---
 rtl/move_seq_pkg.sv | 34 +++
 rtl/move_seq_if.sv | 38 +++
 rtl/move_seq_fifo.sv | 58 +++++
 rtl/move_seq.sv | 179 +++++++++++++++++
 tb/tb_move_seq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_seq_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg : shared definitions for the move command sequencer.
//   - opcode constants understood by the `move` motor block
//   - command word width ({op[2:0], operand[31:0]})
//   - sequencer FSM state encoding
//   - max3() helper used to size counters
// Configuration macro affecting users of this package: MOVE_SEQ_TIMEOUT_EN
// (ST_ABORT is only reached when it is defined).
// -----------------------------------------------------------------------------
package move_pkg;

  localparam logic [2:0] OP_FWD   = 3'd0;
  localparam logic [2:0] OP_BACK  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  localparam int CMD_W = 35;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ABORT   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/move_seq_if.sv
// -----------------------------------------------------------------------------
// move_seq_if : host command channel plus the req/done channel to `move`.
// Handshakes:
//   cmd_valid/cmd_ready : a command {cmd_op, cmd_operand} transfers on a rising
//     CLK edge where both are high; with cmd_ready low the command is dropped.
//   req/done            : req rises with op/operand valid and stays high until
//     the sequencer samples done in its WAIT phase; op/operand never change
//     while req is high.
// Modports:
//   master : the sequencer (consumes host commands, initiates req to `move`)
//   slave  : the environment (host driving commands, `move` answering done)
// Status: busy, error (sticky timeout, MOVE_SEQ_TIMEOUT_EN only), level.
// -----------------------------------------------------------------------------
interface move_seq_if #(
  parameter int DEPTH = 8
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [2:0]               cmd_op;
  logic [31:0]              cmd_operand;
  logic                     req;
  logic [2:0]               op;
  logic [31:0]              operand;
  logic                     done;
  logic                     busy;
  logic                     error;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    input  cmd_valid, cmd_op, cmd_operand, done,
    output cmd_ready, req, op, operand, busy, error, level
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_operand, done,
    input  cmd_ready, req, op, operand, busy, error, level
  );
endinterface

// File: rtl/move_seq_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo : synchronous command FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   CLK, RST        clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_data  write request/data; ignored when full
//   i_pop           read request; ignored when empty
//   i_flush         discard all contents (wins over push and pop)
//   o_data          head entry, valid combinationally while not empty
//   o_full, o_empty, o_level  occupancy status
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_rd <= r_wr;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_level = r_wr - r_rd;
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (r_wr == r_rd);
  assign o_data  = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/move_seq.sv
// -----------------------------------------------------------------------------
// move_seq : queues host move commands and hands them to `move` one at a time
// over the req/done handshake.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   bus          move_seq_if.master (host commands in, req/op/operand out,
//                done in, busy/error/level status out)
//   o_dbg_state  current FSM state
// Parameters: DEPTH (FIFO entries), GUARD (cycles after req rise where done is
// ignored), GAP (min req-low cycles between commands), TIMEOUT (WAIT cycles
// before abort).
// Macro MOVE_SEQ_TIMEOUT_EN: enables the WAIT timeout, the ABORT state (which
// flushes the queue and issues a stop command) and the sticky error flag.
// -----------------------------------------------------------------------------
module move_seq
  import move_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter int          GUARD   = 3,
  parameter int          GAP     = 2,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  move_seq_if.master bus,
  output state_t     o_dbg_state
);
  // One counter serves guard, gap and timeout phases; it is sized for the
  // longest of them.
  localparam int CNT_W = $clog2(max3(GUARD, GAP, int'(TIMEOUT)) + 1);
  // ISSUE lasts GUARD-1 cycles so that WAIT first samples done exactly GUARD
  // edges after req rose.
  localparam logic [CNT_W-1:0] GUARD_TURN = CNT_W'((GUARD >= 2) ? GUARD - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP >= 1) ? GAP - 1 : 0);

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_req, w_req_nxt;
  logic [2:0]             r_op;
  logic [31:0]            r_operand;
  logic                   w_pop, w_load_fifo, w_load_stop, w_flush;
  logic [CMD_W-1:0]       w_fifo_data;
  logic                   w_full, w_empty;
  logic [$clog2(DEPTH):0] w_level;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (bus.cmd_valid),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({bus.cmd_op, bus.cmd_operand}),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT >= 32'd1) ? TIMEOUT - 32'd1 : 32'd0);
  logic r_error;
  logic w_set_error;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_pop       = 1'b0;
    w_load_fifo = 1'b0;
    w_load_stop = 1'b0;
    w_flush     = 1'b0;
`ifdef MOVE_SEQ_TIMEOUT_EN
    w_set_error = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load_fifo = 1'b1;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_cnt >= GUARD_TURN) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.done) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
`ifdef MOVE_SEQ_TIMEOUT_EN
        else if (r_cnt >= TMO_LAST) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_set_error = 1'b1;
          w_state_nxt = ST_ABORT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        if (r_cnt >= GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef MOVE_SEQ_TIMEOUT_EN
      ST_ABORT: begin
        // Queue stays flushed for the whole abort so nothing stale survives.
        w_flush     = 1'b1;
        w_set_error = 1'b1;
        if (r_cnt >= GAP_LAST) begin
          w_load_stop = 1'b1;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      default: begin
        w_req_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_op      <= OP_FWD;
      r_operand <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      if (w_load_fifo) begin
        {r_op, r_operand} <= w_fifo_data;
      end else if (w_load_stop) begin
        r_op      <= OP_STOP;
        r_operand <= '0;
      end
    end
  end

`ifdef MOVE_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              r_error <= 1'b0;
    else if (w_set_error) r_error <= 1'b1;
  end
  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.cmd_ready = !w_full;
  assign bus.req       = r_req;
  assign bus.op        = r_op;
  assign bus.operand   = r_operand;
  assign bus.busy      = (r_state != ST_IDLE) || !w_empty;
  assign bus.level     = w_level;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_move_seq.sv
// -----------------------------------------------------------------------------
// tb_move_seq : bench for move_seq. A random `move` responder answers each req
// with done after a chosen delay; the expected req-high length follows from
// that delay and GUARD. Commands accepted by the host side are queued as
// expectations and checked in order when req rises.
// -----------------------------------------------------------------------------
module tb_move_seq;
  import move_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          GUARD = 3;
  localparam int          GAP   = 2;
  localparam logic [31:0] TMO   = 32'd100;

  // ---------------- clock / reset ----------------
  logic   CLK = 1'b0;
  logic   RST = 1'b1;
  state_t dbg_state;

  always #5 CLK = ~CLK;

  move_seq_if #(.DEPTH(DEPTH)) bus ();

  move_seq #(.DEPTH(DEPTH), .GUARD(GUARD), .GAP(GAP), .TIMEOUT(TMO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [CMD_W-1:0] exp_q[$];
  int               len_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_acc   = 0;
  int               n_rise  = 0;
  int               gap_min = GAP + 1;
  bit               manual  = 1'b0;
  bit               release_now = 1'b0;
  int               force_k = -1;

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [2:0] op, input logic [31:0] opd);
    int occ;
    occ = n_acc - n_rise;
    check_eq("cmd_ready", bus.cmd_ready, (occ < DEPTH));
    check_eq("level", bus.level, occ);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = opd;
    if (occ < DEPTH) begin
      exp_q.push_back({op, opd});
      n_acc++;
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string nm);
    int i;
    i = 0;
    while (bus.req !== lvl && i < budget) begin
      tick();
      i++;
    end
    check_eq(nm, bus.req, lvl);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus.req) && i < budget) begin
      tick();
      i++;
    end
    check_eq("drain_done", (i < budget), 1'b1);
    repeat (GAP + 2) tick();
    check_eq("idle_busy", bus.busy, 1'b0);
    check_eq("idle_level", bus.level, n_acc - n_rise);
  endtask

  // ---------------- move responder ----------------
  int resp_cnt  = -1;
  bit resp_prev = 1'b0;
  bit resp_pend = 1'b0;

  initial begin
    int k;
    bus.done = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        bus.done  = 1'b0;
        resp_cnt  = -1;
        resp_prev = 1'b0;
        resp_pend = 1'b0;
      end else begin
        if (!bus.req) begin
          bus.done  = 1'b0;
          resp_cnt  = -1;
          resp_pend = 1'b0;
        end
        if (bus.req && !resp_prev) begin
          if (manual) begin
            resp_pend = 1'b1;
          end else begin
            if (force_k >= 0) k = force_k;
            else if ($urandom_range(0, 3) == 0) k = 0;
            else k = $urandom_range(0, 20);
            force_k = -1;
            // done raised k negedges after the rise; WAIT cannot act before GUARD.
            len_q.push_back((k + 1 > GUARD) ? k + 1 : GUARD);
            resp_cnt = k;
          end
        end
        if (bus.req && !bus.done) begin
          if (resp_pend && release_now) begin
            bus.done    = 1'b1;
            resp_pend   = 1'b0;
            release_now = 1'b0;
          end else if (resp_cnt == 0) begin
            bus.done = 1'b1;
            resp_cnt = -1;
          end else if (resp_cnt > 0) begin
            resp_cnt--;
          end
        end
        resp_prev = bus.req;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit               m_prev, m_first, m_stable;
    int               m_hi, m_lo, l;
    logic [CMD_W-1:0] cur;
    m_prev = 1'b0; m_first = 1'b1; m_stable = 1'b1; m_hi = 0; m_lo = 0; cur = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_prev  = 1'b0;
        m_first = 1'b1;
        m_hi    = 0;
        m_lo    = 0;
      end else begin
        if (bus.req && !m_prev) begin
          n_rise++;
          check_eq("issue_avail", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_eq("issue_cmd", {bus.op, bus.operand}, cur);
          end
          if (!m_first) check_eq("req_gap", (m_lo >= gap_min), 1'b1);
          m_first  = 1'b0;
          m_hi     = 1;
          m_stable = 1'b1;
        end else if (bus.req) begin
          m_hi++;
          if ({bus.op, bus.operand} !== cur) m_stable = 1'b0;
        end else if (m_prev) begin
          check_eq("hold_cmd", m_stable, 1'b1);
          check_eq("len_avail", (len_q.size() > 0), 1'b1);
          if (len_q.size() > 0) begin
            l = len_q.pop_front();
            if (l >= 0) check_eq("req_len", m_hi, l);
          end
          m_lo = 1;
        end else begin
          m_lo++;
        end
        m_prev = bus.req;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'd0;
    bus.cmd_operand = 32'd0;
    RST = 1'b1;
    repeat (3) tick();
    check_eq("rst_req", bus.req, 1'b0);
    check_eq("rst_op", bus.op, 3'd0);
    check_eq("rst_operand", bus.operand, 32'd0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_error", bus.error, 1'b0);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    RST = 1'b0;
    tick();

    // Single command with done 20 cycles after req rise; latency check.
    force_k = 19;
    push(OP_FWD, 32'd1000);
    check_eq("lat_edge_n", bus.req, 1'b0);
    tick();
    check_eq("lat_req", bus.req, 1'b1);
    check_eq("lat_op", bus.op, OP_FWD);
    check_eq("lat_operand", bus.operand, 32'd1000);
    wait_req(1'b0, 40, "single_fall");
    check_eq("single_level", bus.level, 0);
    wait_idle(100);

    // done already high at req rise: req must last exactly GUARD cycles.
    force_k = 0;
    push(OP_BACK, 32'd42);
    wait_idle(100);

    // Back-to-back queue: occupancy peaks at 3.
    push(OP_FWD, 32'd10);
    push(OP_BACK, 32'd11);
    push(OP_LEFT, 32'd12);
    push(OP_RIGHT, 32'd13);
    check_eq("peak_level", bus.level, 3);
    wait_idle(400);

    // Full FIFO while one command is held in WAIT.
    manual = 1'b1;
    push(OP_FWD, 32'd500);
    wait_req(1'b1, 10, "full_rise");
    len_q.push_back(-1);
    for (int i = 0; i < 9; i++) push(3'(i % 8), 32'd600 + 32'(i));
    check_eq("full_ready", bus.cmd_ready, ((n_acc - n_rise) < DEPTH));
    check_eq("full_level", bus.level, n_acc - n_rise);
    release_now = 1'b1;
    manual = 1'b0;
    wait_idle(3000);

    // Random commands, including opcodes 5..7, with random host pacing.
    for (int i = 0; i < 40; i++) begin
      push(3'($urandom_range(0, 7)), $urandom);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(4000);

`ifdef MOVE_SEQ_TIMEOUT_EN
    // done never comes: abort, flush, stop command, sticky error.
    manual = 1'b1;
    push(OP_LEFT, 32'd55);
    wait_req(1'b1, 10, "to_rise");
    len_q.push_back(GUARD - 1 + int'(TMO));
    push(OP_FWD, 32'd1);
    push(OP_BACK, 32'd2);
    wait_req(1'b0, int'(TMO) + 50, "to_fall");
    manual = 1'b0;
    check_eq("to_error", bus.error, 1'b1);
    exp_q.delete();
    exp_q.push_back({OP_STOP, 32'd0});
    n_acc = n_rise + 1;
    gap_min = GAP;
    wait_req(1'b1, GAP + 5, "stop_rise");
    gap_min = GAP + 1;
    check_eq("to_flushed", bus.level, 0);
    wait_idle(200);
    check_eq("to_sticky", bus.error, 1'b1);
`endif

    // Asynchronous reset while a command is held in WAIT.
    manual = 1'b1;
    push(OP_BACK, 32'd77);
    wait_req(1'b1, 10, "rstw_rise");
    len_q.push_back(-1);
    push(OP_LEFT, 32'd88);
    repeat (GUARD + 1) tick();
    #2 RST = 1'b1;
    #1;
    check_eq("rstw_req", bus.req, 1'b0);
    check_eq("rstw_level", bus.level, 0);
    check_eq("rstw_state", dbg_state, ST_IDLE);
    check_eq("rstw_error", bus.error, 1'b0);
    check_eq("rstw_ready", bus.cmd_ready, 1'b1);
    exp_q.delete();
    len_q.delete();
    n_acc = 0;
    n_rise = 0;
    manual = 1'b0;
    release_now = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Recovery after reset.
    push(OP_RIGHT, 32'd5);
    wait_idle(100);
    check_eq("final_error", bus.error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
